// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg: shared states, opcodes and transfer codes for the sequencer
package seq_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, EXEC2, ADVANCE, HALT} stateT;
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_CLR   = 4'h1;
  localparam logic [3:0] OP_LDX   = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_MVZ   = 4'h5;
  localparam logic [3:0] OP_SHRY  = 4'h6;
  localparam logic [3:0] OP_LDADD = 4'h7;
  localparam logic [3:0] OP_HLT   = 4'hF;
  localparam logic [1:0] T_HOLD  = 2'b00;
  localparam logic [1:0] T_LOAD  = 2'b01;
  localparam logic [1:0] T_CLEAR = 2'b10;
  localparam logic [1:0] T_SHR   = 2'b11;
endpackage

// File: rtl/seq_decode.sv
// seq_decode: maps the latched instruction and execute phase to datapath controls
import seq_ctrl_pkg::*;
module seq_decode (
  input  logic [3:0] ir,
  input  stateT      phase,
  output logic [1:0] tx,
  output logic [1:0] ty,
  output logic [1:0] tz,
  output logic       tula,
  output logic       illegal
);
  always_comb begin
    tx = T_HOLD;
    ty = T_HOLD;
    tz = T_HOLD;
    tula = 1'b0;
    illegal = 1'b0;
    if (phase == EXEC) begin
      case (ir)
        OP_NOP, OP_HLT: ;
        OP_CLR: begin tx = T_CLEAR; ty = T_CLEAR; tz = T_CLEAR; end
        OP_LDX, OP_LDADD: tx = T_LOAD;
        OP_ADD: ty = T_LOAD;
        OP_SUB: begin ty = T_LOAD; tula = 1'b1; end
        OP_MVZ: tz = T_LOAD;
        OP_SHRY: ty = T_SHR;
        default: illegal = 1'b1;
      endcase
    end else if (phase == EXEC2 && ir == OP_LDADD) begin
      ty = T_LOAD;
    end
  end
endmodule

// File: rtl/seq_control.sv
// seq_control: multi-cycle sequencer driving X/Y/Z/ULA transfers and PC advance
import seq_ctrl_pkg::*;
module seq_control #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [3:0]       funcao,
  output logic [1:0]       tx,
  output logic [1:0]       ty,
  output logic [1:0]       tz,
  output logic             tula,
  output logic             pc_inc,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);
  stateT state, nextState;
  logic [3:0] ir;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ir <= '0;
      retired <= '0;
    end else begin
      state <= nextState;
      if (state == FETCH) ir <= funcao;
      if (state == ADVANCE && !(&retired)) retired <= retired + CNT_W'(1);
    end
  end
  always_comb begin
    nextState = IDLE;
    case (state)
      IDLE: nextState = run ? FETCH : IDLE;
      FETCH: nextState = EXEC;
      EXEC: nextState = ir == OP_HLT ? HALT : ir == OP_LDADD ? EXEC2 : ADVANCE;
      EXEC2: nextState = ADVANCE;
      ADVANCE: nextState = run ? FETCH : IDLE;
      HALT: nextState = HALT;
      default: nextState = IDLE;
    endcase
  end
  assign pc_inc = state == ADVANCE;
  assign halted = state == HALT;
  assign busy = state != IDLE && state != HALT;
  seq_decode u_decode (
    .ir(ir),
    .phase(state),
    .tx(tx),
    .ty(ty),
    .tz(tz),
    .tula(tula),
    .illegal(illegal)
  );
endmodule

// File: tb/tb_seq_control.sv
// tb_seq_control: scoreboard bench; expected control events are queued with their cycle
module tb_seq_control;
  typedef struct {
    int cyc;
    logic [1:0] tx, ty, tz;
    logic tula, ill, pc;
    logic [7:0] ret;
  } expT;

  logic clk = 0, rst = 1, run = 0;
  logic [3:0] funcao;
  logic [1:0] tx, ty, tz;
  logic tula, pc_inc, busy, halted, illegal;
  logic [7:0] retired;
  logic [3:0] prog [16];
  logic [3:0] pc;
  int cyc = 0, total = 0, bad = 0;
  expT sb[$];

  seq_control dut (
    .clk(clk), .rst(rst), .run(run), .funcao(funcao),
    .tx(tx), .ty(ty), .tz(tz), .tula(tula), .pc_inc(pc_inc),
    .busy(busy), .halted(halted), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) pc <= rst ? 4'd0 : pc_inc ? pc + 4'd1 : pc;
  assign funcao = prog[pc];

  always @(negedge clk) begin
    if (tx != 2'd0 || ty != 2'd0 || tz != 2'd0 || tula || illegal || pc_inc) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event cyc=%0d got tx=%0d ty=%0d tz=%0d tula=%0d ill=%0d pc_inc=%0d", cyc, tx, ty, tz, tula, illegal, pc_inc);
      end else begin
        expT e;
        e = sb.pop_front();
        if (e.cyc != cyc || e.tx != tx || e.ty != ty || e.tz != tz || e.tula != tula || e.ill != illegal || e.pc != pc_inc || e.ret != retired) begin
          bad++;
          $display("FAIL event got cyc=%0d tx=%0d ty=%0d tz=%0d tula=%0d ill=%0d pc=%0d ret=%0d expected cyc=%0d tx=%0d ty=%0d tz=%0d tula=%0d ill=%0d pc=%0d ret=%0d",
                   cyc, tx, ty, tz, tula, illegal, pc_inc, retired, e.cyc, e.tx, e.ty, e.tz, e.tula, e.ill, e.pc, e.ret);
        end
      end
    end
  end

  function automatic void push(int c, logic [1:0] x, logic [1:0] y, logic [1:0] z, logic u, logic il, logic p, logic [7:0] r);
    expT e;
    e.cyc = c; e.tx = x; e.ty = y; e.tz = z; e.tula = u; e.ill = il; e.pc = p; e.ret = r;
    sb.push_back(e);
  endfunction

  task automatic step(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, act, want);
    end
  endtask

  task automatic doReset();
    rst = 1;
    run = 0;
    step(2);
    rst = 0;
    step(1);
  endtask

  initial begin
    int c0;
    logic [3:0] mix [5];
    for (int i = 0; i < 16; i++) prog[i] = 4'h0;
    doReset();
    chk("reset_tx", {30'd0, tx}, 0);
    chk("reset_ty", {30'd0, ty}, 0);
    chk("reset_tz", {30'd0, tz}, 0);
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_halted", {31'd0, halted}, 0);
    chk("reset_retired", {24'd0, retired}, 0);

    prog[0] = 4'h3;
    c0 = cyc;
    push(c0 + 2, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0);
    push(c0 + 3, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0);
    run = 1;
    step(1);
    chk("add_busy_fetch", {31'd0, busy}, 1);
    run = 0;
    step(4);
    chk("add_retired", {24'd0, retired}, 1);
    chk("add_idle_busy", {31'd0, busy}, 0);

    doReset();
    prog[0] = 4'h2; prog[1] = 4'h7; prog[2] = 4'h5;
    c0 = cyc;
    push(c0 + 2,  2'b01, 2'b00, 2'b00, 0, 0, 0, 0);
    push(c0 + 3,  2'b00, 2'b00, 2'b00, 0, 0, 1, 0);
    push(c0 + 5,  2'b01, 2'b00, 2'b00, 0, 0, 0, 1);
    push(c0 + 6,  2'b00, 2'b01, 2'b00, 0, 0, 0, 1);
    push(c0 + 7,  2'b00, 2'b00, 2'b00, 0, 0, 1, 1);
    push(c0 + 9,  2'b00, 2'b00, 2'b01, 0, 0, 0, 2);
    push(c0 + 10, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2);
    run = 1;
    step(8);
    run = 0;
    step(4);
    chk("prog3_retired", {24'd0, retired}, 3);
    chk("prog3_pc", {28'd0, pc}, 3);

    doReset();
    mix[0] = 4'h4; mix[1] = 4'h1; mix[2] = 4'h6; mix[3] = 4'hA; mix[4] = 4'h0;
    for (int k = 0; k < 5; k++) prog[k] = mix[k];
    c0 = cyc;
    push(c0 + 2,  2'b00, 2'b01, 2'b00, 1, 0, 0, 0);
    push(c0 + 3,  2'b00, 2'b00, 2'b00, 0, 0, 1, 0);
    push(c0 + 5,  2'b10, 2'b10, 2'b10, 0, 0, 0, 1);
    push(c0 + 6,  2'b00, 2'b00, 2'b00, 0, 0, 1, 1);
    push(c0 + 8,  2'b00, 2'b11, 2'b00, 0, 0, 0, 2);
    push(c0 + 9,  2'b00, 2'b00, 2'b00, 0, 0, 1, 2);
    push(c0 + 11, 2'b00, 2'b00, 2'b00, 0, 1, 0, 3);
    push(c0 + 12, 2'b00, 2'b00, 2'b00, 0, 0, 1, 3);
    push(c0 + 15, 2'b00, 2'b00, 2'b00, 0, 0, 1, 4);
    run = 1;
    step(13);
    run = 0;
    step(4);
    chk("mix_retired", {24'd0, retired}, 5);

    doReset();
    for (int i = 0; i < 16; i++) prog[i] = 4'h0;
    prog[0] = 4'hF;
    run = 1;
    step(2);
    chk("hlt_exec_halted", {31'd0, halted}, 0);
    chk("hlt_exec_busy", {31'd0, busy}, 1);
    step(1);
    chk("hlt_halted", {31'd0, halted}, 1);
    chk("hlt_busy", {31'd0, busy}, 0);
    for (int i = 0; i < 20; i++) begin
      run = ~run;
      step(1);
    end
    chk("hlt_sticky", {31'd0, halted}, 1);
    chk("hlt_retired", {24'd0, retired}, 0);
    chk("hlt_pc", {28'd0, pc}, 0);
    doReset();
    chk("hlt_reset_clears", {31'd0, halted}, 0);

    prog[0] = 4'h7;
    c0 = cyc;
    push(c0 + 2, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0);
    run = 1;
    step(2);
    rst = 1;
    run = 0;
    step(1);
    chk("rst_exec_busy", {31'd0, busy}, 0);
    chk("rst_exec_pcinc", {31'd0, pc_inc}, 0);
    chk("rst_exec_ty", {30'd0, ty}, 0);
    rst = 0;
    step(3);
    chk("rst_exec_retired", {24'd0, retired}, 0);
    chk("rst_exec_idle", {31'd0, busy}, 0);

    prog[0] = 4'h0;
    c0 = cyc;
    for (int k = 0; k < 300; k++) push(c0 + 3 + 3 * k, 2'b00, 2'b00, 2'b00, 0, 0, 1, k < 255 ? 8'(k) : 8'd255);
    run = 1;
    step(1 + 3 * 299);
    run = 0;
    step(4);
    chk("nop_saturate", {24'd0, retired}, 255);
    chk("nop_idle_busy", {31'd0, busy}, 0);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_control.md
# seq_control

Multi-cycle sequencer for the 4-bit X/Y/Z/ULA datapath. Each instruction nibble from instruction memory is latched into an instruction register and executed over a fixed number of cycles. The block drives the register transfer codes, the ULA operation select and the PC advance enable. It replaces the single-cycle combinational decoder and makes the PC step only when an instruction retires.

## Interface
Parameters:
- `CNT_W`, default 8: width of the retired-instruction counter.

Ports:
- `clk` input 1: system clock. All state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `run` input 1: level. Start or continue execution.
- `funcao` input 4: instruction nibble from memory at the current PC.
- `tx` output 2: transfer code for REGX.
- `ty` output 2: transfer code for REGY.
- `tz` output 2: transfer code for REGZ.
- `tula` output 1: ULA op select, 0 = add, 1 = subtract.
- `pc_inc` output 1: PC advance enable. Single-cycle pulse.
- `busy` output 1: high in every state except IDLE and HALT.
- `halted` output 1: sticky, high in HALT.
- `illegal` output 1: one-cycle pulse for an undefined opcode.
- `retired` output CNT_W: count of retired instructions.

## Operation
Transfer codes:
- HOLD = 00, LOAD = 01, CLEAR = 10, SHR = 11.

Opcodes:
- 0x0 NOP: no transfer.
- 0x1 CLR: tx = ty = tz = CLEAR.
- 0x2 LDX: tx = LOAD.
- 0x3 ADD: tula = 0, ty = LOAD.
- 0x4 SUB: tula = 1, ty = LOAD.
- 0x5 MVZ: tz = LOAD.
- 0x6 SHRY: ty = SHR.
- 0x7 LDADD: EXEC drives tx = LOAD; EXEC2 drives tula = 0, ty = LOAD.
- 0xF HLT: enters HALT.
- 0x8–0xE: illegal. Executed as NOP, `illegal` = 1 during EXEC.

States:
- IDLE: if `run` = 1, go to FETCH.
- FETCH: IR <= `funcao`; go to EXEC.
- EXEC: if IR = HLT, go to HALT. Else if IR = LDADD, go to EXEC2. Else go to ADVANCE.
- EXEC2: go to ADVANCE.
- ADVANCE: `pc_inc` = 1 and `retired` increments. If `run` = 1 go to FETCH, else go to IDLE.
- HALT: absorbing. Leave only via `rst`. `run` is ignored.

Output rules:
- Outputs are a pure function of state and IR. There is no combinational path from `funcao` or `run` to any output.
- Outside EXEC and EXEC2, tx = ty = tz = HOLD and tula = 0.
- `retired` saturates at 2^CNT_W−1.
- Dropping `run` mid-instruction does not abort: the instruction completes through ADVANCE, then the FSM goes to IDLE.
- HLT does not increment `retired` and does not pulse `pc_inc`.

## Timing
- Reset (next edge after `rst` = 1, from any state): state = IDLE, IR = 0, `retired` = 0. All outputs 0 or HOLD, `halted` = 0. A reset during EXEC/EXEC2 suppresses any pending `pc_inc`.
- `run` rises in cycle n: FETCH in n+1, EXEC in n+2 (datapath registers update at the end of n+2), ADVANCE in n+3. The PC changes at the end of n+3.
- Throughput: 3 cycles per instruction (LDADD: 4) with `run` held high.
- `funcao` must be stable during FETCH only. The PC is constant from FETCH through ADVANCE, which guarantees this.
- `halted` rises in the cycle after EXEC of HLT and stays high until reset.

## Structure
- Package `seq_ctrl_pkg` holds:
  - the state enum (IDLE, FETCH, EXEC, EXEC2, ADVANCE, HALT);
  - the 4-bit opcode constants;
  - the 2-bit transfer-code constants (HOLD/LOAD/CLEAR/SHR).
- One combinational sub-module, `seq_decode`, maps (IR, phase) to {tx, ty, tz, tula, illegal}. Phase is EXEC or EXEC2. The FSM, IR and counter stay in `seq_control`.
- Integration: the system PC needs its increment gated by `pc_inc`.

## Test plan
- Reset, then `run` = 1 with `funcao` = 0x3: EXEC cycle shows ty = 01, tula = 0. `pc_inc` pulses exactly once, 3 cycles after `run`. `retired` = 1.
- Program 0x2, 0x7, 0x5 with `run` held high: `pc_inc` pulses at cycles 3, 7, 10. The 0x7 shows tx = 01 then ty = 01 on consecutive cycles. `retired` = 3.
- `funcao` = 0xA: `illegal` = 1 for exactly the EXEC cycle, all transfer codes 00, `pc_inc` pulses, `retired` increments.
- `funcao` = 0xF: `halted` = 1 from cycle 3 and stays there. No `pc_inc`, even with `run` toggled for 20 cycles. `rst` clears `halted`.
- Assert `rst` during EXEC of 0x7: next cycle state = IDLE, outputs HOLD, no `pc_inc`, `retired` = 0.
- Drop `run` during FETCH: instruction completes, `pc_inc` pulses once, FSM returns to IDLE and `busy` = 0. Run 300 NOPs: `retired` saturates at 255.
